instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Sequences one instruction fetch per request. It captures the program counter into an internal memory address register, issues a read to instruction memory, and waits for the memory acknowledge. It then latches the returned word into the instruction register and pulses the PC increment strobe. The block sits directly downstream of the program counter register: it consumes the PC's Q output and drives the PC's increment input.

## Interface
- ADDR_W, 9: memory word-address width; `mem_addr` carries `pc_q[ADDR_W-1:0]`.
- TIMEOUT, 16: maximum READ cycles without `mem_ack` before faulting; legal range 1..255.
- clk  in  1  single system clock; all state changes on its rising edge.
- clr  in  1  reset, synchronous, active-high; sampled on the rising edge of clk.
- pc_q  in  32  current program counter value.
- fetch_req  in  1  level request for the next fetch; sampled in IDLE and DONE.
- flush  in  1  abort the in-flight fetch (branch/redirect); also clears a fault.
- mem_ack  in  1  instruction memory has valid `mem_data` this cycle.
- mem_data  in  32  instruction word from memory.
- mem_addr  out  ADDR_W  word address to memory (registered MAR).
- mem_rd  out  1  read strobe; high exactly while in READ.
- ir  out  32  instruction register.
- ir_valid  out  1  one-cycle pulse: `ir` updated with a new instruction.
- pc_increment  out  1  one-cycle pulse, wired to the PC increment input.
- busy  out  1  high in ADDR, READ, DONE.
- fault  out  1  sticky fetch-timeout flag.

## Operation
- States: IDLE, ADDR, READ, DONE, FAULT. State register is binary-encoded; outputs are decoded from registered state or registered directly.
- IDLE
  - `fetch_req` = 1 → ADDR; otherwise stay.
- ADDR
  - On the exiting edge: `mar <= pc_q[ADDR_W-1:0]`, clear the wait counter, → READ.
  - `pc_q` is sampled here, one cycle after any increment, so the post-increment PC is always used.
- READ
  - `mem_rd` = 1, `mem_addr` = mar, held stable.
  - `mem_ack` = 1 → `ir <= mem_data`, → DONE.
  - No ack → wait counter +1. If the counter reaches TIMEOUT-1 without ack → FAULT, `fault <= 1`.
- DONE
  - `ir_valid` = 1 and `pc_increment` = 1 for exactly this cycle.
  - `fetch_req` = 1 → ADDR (back-to-back fetch); otherwise → IDLE.
- FAULT
  - `mem_rd` = 0; `fetch_req` is ignored; `fault` stays 1.
  - Leave only via `flush` or `clr`.
- flush
  - From any state, on the next edge → IDLE.
  - Clears `fault` and the wait counter.
  - `ir`, `mar` unchanged; no `ir_valid` or `pc_increment` pulse.
  - Priority over `mem_ack` in the same cycle: the memory data is discarded.
- Priority per edge: clr > flush > mem_ack > timeout > fetch_req.
- Wait counter is 8 bits; it never wraps, because TIMEOUT ≤ 255.
- No arithmetic is performed on PC; incrementing is the PC register's job.

## Timing
- Reset, the edge with clr = 1:
  - state = IDLE
  - mar = 0, ir = 0, wait counter = 0
  - mem_rd = 0, ir_valid = 0, pc_increment = 0, busy = 0, fault = 0
- clr mid-fetch: the same reset values apply immediately; a pending `mem_ack` is ignored.
- Best-case latency, `fetch_req` sampled at edge 0:
  - ADDR in cycle 0→1
  - READ in cycle 1→2; with ack in that cycle, `ir` is valid after edge 2
  - DONE (`ir_valid`, `pc_increment`) in cycle 2→3
- With N wait cycles before ack, `ir_valid` is delayed by N.
- Sustained throughput with zero-wait memory: one instruction per 3 cycles.
- `mem_addr` changes only on the edge leaving ADDR; it is stable throughout READ.
- `pc_increment` and the DONE→ADDR transition share an edge, so the PC holds the new value during the following ADDR cycle.
- Timeout: FAULT is entered on the TIMEOUT-th READ cycle without ack; `fault` is visible the next cycle.

## Test plan
- **Reset and single fetch.**
  - Stimulus: clr for 2 cycles, `pc_q` = 0x00000010, `fetch_req` pulse, memory acks on the first READ cycle with 0xA5A5_0001.
  - Response: `mem_addr` = 0x010; `mem_rd` high for 1 cycle; `ir` = 0xA5A50001; `ir_valid` and `pc_increment` each high for exactly 1 cycle, 3 cycles after the request.
- **Wait states.**
  - Stimulus: ack delayed 4 cycles.
  - Response: `mem_rd` high 5 cycles, `mem_addr` constant, `ir_valid` on cycle 7, `fault` = 0.
- **Back-to-back with live PC model.**
  - Stimulus: `fetch_req` held high, PC starts at 0x20, zero-wait memory returning the address as data.
  - Response: fetch addresses 0x20, 0x21, 0x22; `ir` values 0x20, 0x21, 0x22; `ir_valid` every 3rd cycle.
- **Timeout.**
  - Stimulus: TIMEOUT = 4, no ack.
  - Response: FAULT after 4 READ cycles, `fault` = 1, `mem_rd` = 0.
  - Follow-up: further `fetch_req` is ignored; `flush` clears `fault` and returns to IDLE.
- **Flush vs ack.**
  - Stimulus: `flush` and `mem_ack` in the same READ cycle with data 0xDEADBEEF.
  - Response: `ir` keeps its previous value; no `ir_valid`, no `pc_increment`; IDLE next cycle.
- **Mid-fetch clr.**
  - Stimulus: clr asserted during READ with ack high.
  - Response: all outputs at reset values next cycle; `ir` = 0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// The master drives a registered word address and a read strobe; the slave returns an ack and the data word.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [31:0]       mem_data;

  modport master (output mem_addr, mem_rd, input  mem_ack, mem_data);
  modport slave  (input  mem_addr, mem_rd, output mem_ack, mem_data);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: captures the PC into the MAR, reads instruction memory, latches the IR,
// and pulses the PC increment. A read that waits too long parks the block in a sticky fault.
module instruction_fetch_unit #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic [31:0]                      pc_q,
  input  logic                             fetch_req,
  input  logic                             flush,
  instruction_fetch_unit_if.master         bus,
  output logic [31:0]                      ir,
  output logic                             ir_valid,
  output logic                             pc_increment,
  output logic                             busy,
  output logic                             fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar;
  logic [7:0]        wait_cnt;
  logic              load_mar, load_ir, cnt_clr, cnt_inc, set_fault;

  // Only the word-address bits of the PC reach memory.
  logic unused_pc_hi;
  assign unused_pc_hi = &{1'b0, pc_q[31:ADDR_W]};

  // Priority per edge: clr (in the register block) > flush > mem_ack > timeout > fetch_req.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    load_mar  = 1'b0;
    load_ir   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    set_fault = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (fetch_req) state_d = S_ADDR;
        S_ADDR: begin
          load_mar = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = S_READ;
        end
        S_READ: begin
          if (bus.mem_ack) begin
            load_ir = 1'b1;
            state_d = S_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            set_fault = 1'b1;
            state_d   = S_FAULT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        S_DONE:  state_d = fetch_req ? S_ADDR : S_IDLE;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values, matching hardware.
    if (clr) begin
      state_q  <= S_IDLE;
      mar      <= '0;
      ir       <= '0;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_mar) mar <= pc_q[ADDR_W-1:0];
      if (load_ir)  ir  <= bus.mem_data;
      if (cnt_clr)      wait_cnt <= '0;
      else if (cnt_inc) wait_cnt <= wait_cnt + 8'd1;
      if (flush)          fault <= 1'b0;
      else if (set_fault) fault <= 1'b1;
    end
  end

  assign bus.mem_addr = mar;
  assign bus.mem_rd   = (state_q == S_READ);
  assign ir_valid     = (state_q == S_DONE);
  assign pc_increment = (state_q == S_DONE);
  assign busy         = (state_q == S_ADDR) || (state_q == S_READ) || (state_q == S_DONE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a default-timeout instance for the main flows
// and a TIMEOUT=4 instance for the fault path, both sharing clock, reset and control inputs.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        clr, fetch_req, flush, ack_r;
  logic [31:0] pc_q, data_r;
  bit          auto_mem, live_pc;
  int          n_cmp = 0;
  int          n_err = 0;

  logic [31:0] ir,  ir2;
  logic        ir_valid, pc_increment, busy, fault;
  logic        ir_valid2, pc_increment2, busy2, fault2;

  instruction_fetch_unit_if #(.ADDR_W(9)) bus  ();
  instruction_fetch_unit_if #(.ADDR_W(9)) bus2 ();

  // Zero-wait memory returning its own address when auto_mem is set; otherwise directed ack/data.
  assign bus.mem_ack   = auto_mem ? bus.mem_rd : ack_r;
  assign bus.mem_data  = auto_mem ? {23'd0, bus.mem_addr} : data_r;
  assign bus2.mem_ack  = ack_r;
  assign bus2.mem_data = data_r;

  instruction_fetch_unit #(.ADDR_W(9), .TIMEOUT(16)) u_dut (
    .clk(clk), .clr(clr), .pc_q(pc_q), .fetch_req(fetch_req), .flush(flush),
    .bus(bus), .ir(ir), .ir_valid(ir_valid), .pc_increment(pc_increment),
    .busy(busy), .fault(fault)
  );

  instruction_fetch_unit #(.ADDR_W(9), .TIMEOUT(4)) u_dut_to (
    .clk(clk), .clr(clr), .pc_q(pc_q), .fetch_req(fetch_req), .flush(flush),
    .bus(bus2), .ir(ir2), .ir_valid(ir_valid2), .pc_increment(pc_increment2),
    .busy(busy2), .fault(fault2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the rising edge.
  // The live PC model increments when the DUT showed pc_increment during the cycle just ended.
  task automatic tick();
    logic inc;
    inc = pc_increment;
    @(posedge clk);
    #1;
    if (live_pc && inc) pc_q = pc_q + 32'd1;
  endtask

  initial begin
    clr = 1'b1; fetch_req = 1'b0; flush = 1'b0; ack_r = 1'b0;
    pc_q = 32'h0; data_r = 32'h0; auto_mem = 1'b0; live_pc = 1'b0;

    // Reset and single fetch
    tick(); tick();
    check("rst_mem_rd",   32'(bus.mem_rd),   32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_ir",       ir,                32'd0);
    check("rst_ir_valid", 32'(ir_valid),     32'd0);
    check("rst_pc_inc",   32'(pc_increment), 32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_fault",    32'(fault),        32'd0);
    clr = 1'b0; pc_q = 32'h0000_0010; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("t1_addr_busy",  32'(busy),       32'd1);
    check("t1_addr_rd",    32'(bus.mem_rd), 32'd0);
    ack_r = 1'b1; data_r = 32'hA5A5_0001;
    tick();
    check("t1_read_rd",    32'(bus.mem_rd),   32'd1);
    check("t1_read_addr",  32'(bus.mem_addr), 32'h010);
    tick();
    ack_r = 1'b0;
    check("t1_done_ir",    ir,                32'hA5A5_0001);
    check("t1_done_valid", 32'(ir_valid),     32'd1);
    check("t1_done_inc",   32'(pc_increment), 32'd1);
    check("t1_done_rd",    32'(bus.mem_rd),   32'd0);
    tick();
    check("t1_idle_valid", 32'(ir_valid),     32'd0);
    check("t1_idle_inc",   32'(pc_increment), 32'd0);
    check("t1_idle_busy",  32'(busy),         32'd0);

    // Wait states: ack arrives in the 5th READ cycle; PC wiggles to show the MAR holds
    pc_q = 32'h0000_0055; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_rd_%0d", i),    32'(bus.mem_rd),   32'd1);
      check($sformatf("t2_addr_%0d", i),  32'(bus.mem_addr), 32'h055);
      check($sformatf("t2_valid_%0d", i), 32'(ir_valid),     32'd0);
      pc_q = 32'h0000_0100 + 32'(i);
      if (i == 4) begin ack_r = 1'b1; data_r = 32'h1234_5678; end
      tick();
    end
    ack_r = 1'b0;
    check("t2_done_valid", 32'(ir_valid), 32'd1);
    check("t2_done_ir",    ir,            32'h1234_5678);
    check("t2_fault",      32'(fault),    32'd0);
    check("t2_done_rd",    32'(bus.mem_rd), 32'd0);
    tick();

    // Back-to-back fetches with a live PC and zero-wait memory
    auto_mem = 1'b1; live_pc = 1'b1; pc_q = 32'h0000_0020; fetch_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t3_addr_valid_%0d", k), 32'(ir_valid), 32'd0);
      tick();
      check($sformatf("t3_mem_addr_%0d", k), 32'(bus.mem_addr), 32'h20 + 32'(k));
      check($sformatf("t3_read_valid_%0d", k), 32'(ir_valid), 32'd0);
      tick();
      check($sformatf("t3_ir_%0d", k),    ir,            32'h20 + 32'(k));
      check($sformatf("t3_valid_%0d", k), 32'(ir_valid), 32'd1);
    end
    fetch_req = 1'b0;
    tick();
    check("t3_pc_final", pc_q,       32'h23);
    check("t3_idle",     32'(busy),  32'd0);
    auto_mem = 1'b0; live_pc = 1'b0;

    // Timeout on the TIMEOUT=4 instance
    clr = 1'b1;
    tick();
    clr = 1'b0; ack_r = 1'b0; pc_q = 32'h0000_01FF; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_rd_%0d", i),    32'(bus2.mem_rd), 32'd1);
      check($sformatf("t4_fault_%0d", i), 32'(fault2),      32'd0);
      tick();
    end
    check("t4_fault_set", 32'(fault2),      32'd1);
    check("t4_fault_rd",  32'(bus2.mem_rd), 32'd0);
    check("t4_fault_busy",32'(busy2),       32'd0);
    fetch_req = 1'b1;
    tick(); tick();
    check("t4_ignore_req_fault", 32'(fault2),      32'd1);
    check("t4_ignore_req_rd",    32'(bus2.mem_rd), 32'd0);
    check("t4_ignore_req_busy",  32'(busy2),       32'd0);
    fetch_req = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_flush_fault", 32'(fault2), 32'd0);
    check("t4_flush_busy",  32'(busy2),  32'd0);
    tick();
    check("t4_stay_idle",   32'(busy2),  32'd0);

    // Flush and ack in the same READ cycle: data dropped, no pulses
    clr = 1'b1;
    tick();
    clr = 1'b0; pc_q = 32'h0000_0020; fetch_req = 1'b1; ack_r = 1'b1; data_r = 32'h0000_0777;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    ack_r = 1'b0;
    check("t5_pre_ir", ir, 32'h0000_0777);
    tick();
    pc_q = 32'h0000_0030; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    check("t5_read_addr", 32'(bus.mem_addr), 32'h030);
    ack_r = 1'b1; data_r = 32'hDEAD_BEEF; flush = 1'b1;
    tick();
    ack_r = 1'b0; flush = 1'b0;
    check("t5_ir_kept", ir,                32'h0000_0777);
    check("t5_valid",   32'(ir_valid),     32'd0);
    check("t5_inc",     32'(pc_increment), 32'd0);
    check("t5_idle",    32'(busy),         32'd0);
    check("t5_mar",     32'(bus.mem_addr), 32'h030);
    tick();
    check("t5_valid_after", 32'(ir_valid), 32'd0);

    // clr during READ with ack high
    pc_q = 32'h0000_0044; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    check("t6_in_read", 32'(bus.mem_rd), 32'd1);
    ack_r = 1'b1; data_r = 32'h8765_4321; clr = 1'b1;
    tick();
    ack_r = 1'b0; clr = 1'b0;
    check("t6_ir",    ir,                32'd0);
    check("t6_addr",  32'(bus.mem_addr), 32'd0);
    check("t6_rd",    32'(bus.mem_rd),   32'd0);
    check("t6_valid", 32'(ir_valid),     32'd0);
    check("t6_inc",   32'(pc_increment), 32'd0);
    check("t6_busy",  32'(busy),         32'd0);
    check("t6_fault", 32'(fault),        32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
